// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   owner_e    : which requester owns the arbiter's burst history
//   sram_cmd_t : one SRAM command (write enable, word address, write data)
//   RD_LAT     : SRAM read latency in cycles (data valid RD_LAT after the strobe)
//   cnt_bump() : saturating increment for the CPU burst counter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_e;

  // Geometry of the attached SRAM; the command struct is sized to it, so the
  // arbiter's ADDR_W/DATA_W must not exceed these.
  localparam int SRAM_ADDR_W = 8;
  localparam int SRAM_DATA_W = 32;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_cmd_t;

  localparam int RD_LAT = 1;

  function automatic logic [3:0] cnt_bump(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt >= limit) ? limit : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Read-return tag pipeline. Every issued read carries a valid bit and a 1-bit
// owner tag (1 = DMA) through two stages: the command register stage and the
// SRAM read-latency stage. The second stage lines up with sram_rd_data and
// produces the per-requester rvalid strobes.
//   clk, rst_n        : clock, synchronous active-low reset (flushes reads in flight)
//   issue_rd          : a read is being granted this cycle
//   issue_dma         : the granted read belongs to the DMA port
//   cpu_rvalid        : CPU read data valid this cycle
//   dma_rvalid        : DMA read data valid this cycle
module sram_rd_tag_pipe (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_rd,
  input  logic issue_dma,
  output logic cpu_rvalid,
  output logic dma_rvalid
);

  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d;
  logic dma_p0_q, dma_p0_d, dma_p1_q, dma_p1_d;

  always_comb begin
    vld_p0_d = issue_rd;
    dma_p0_d = issue_dma;
    vld_p1_d = vld_p0_q;
    dma_p1_d = dma_p0_q;
  end

  // p0: command registered onto the SRAM port; p1: SRAM data returned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      dma_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      dma_p1_q <= 1'b0;
    end else begin
      vld_p0_q <= vld_p0_d;
      dma_p0_q <= dma_p0_d;
      vld_p1_q <= vld_p1_d;
      dma_p1_q <= dma_p1_d;
    end
  end

  // A read whose data would land in a reset cycle is dropped.
  assign cpu_rvalid = vld_p1_q & ~dma_p1_q & rst_n;
  assign dma_rvalid = vld_p1_q &  dma_p1_q & rst_n;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the single SRAM port between the CPU load/store path and the DMA
// loader port. At most one access is granted per cycle using weighted
// round-robin favouring the CPU (up to CPU_BURST consecutive CPU grants while
// DMA waits, never two consecutive DMA grants while CPU waits). A grant in
// cycle N drives the sram_* command in N+1; read data returns to the issuing
// requester in N+2.
//   clk, rst_n                      : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt  : CPU request channel and grant
//   cpu_rvalid, cpu_rdata           : CPU read return
//   dma_*                           : same set for the DMA port
//   sram_raddr, sram_rd             : SRAM read command
//   sram_waddr, sram_wr, sram_wr_data : SRAM write command
//   sram_rd_data                    : SRAM read data, one cycle after sram_rd
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int CPU_BURST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] sram_raddr,
  output logic              sram_rd,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic              sram_wr,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic [DATA_W-1:0] sram_rd_data
);

  localparam logic [3:0] BURST = 4'(CPU_BURST);

  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              grant_cpu, grant_dma, issue;
  sram_cmd_t         cmd;

  logic              sram_rd_q, sram_rd_d, sram_wr_q, sram_wr_d;
  logic [ADDR_W-1:0] sram_raddr_q, sram_raddr_d, sram_waddr_q, sram_waddr_d;
  logic [DATA_W-1:0] sram_wr_data_q, sram_wr_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  // Arbitration: grants are combinational from req and registered owner/cnt.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    owner_d   = IDLE;
    cnt_d     = 4'd0;
    if (rst_n) begin
      unique case ({cpu_req, dma_req})
        2'b10: begin
          grant_cpu = 1'b1;
          owner_d   = CPU;
          cnt_d     = (owner_q == CPU) ? cnt_bump(cnt_q, BURST) : 4'd1;
        end
        2'b01: begin
          grant_dma = 1'b1;
          owner_d   = DMA;
          cnt_d     = (owner_q == DMA) ? cnt_bump(cnt_q, BURST) : 4'd1;
        end
        2'b11: begin
          // CPU keeps the port until its burst allowance is used up; DMA
          // then gets exactly one slot before CPU wins again.
          if (owner_q == CPU && cnt_q >= BURST) begin
            grant_dma = 1'b1;
            owner_d   = DMA;
            cnt_d     = 4'd1;
          end else begin
            grant_cpu = 1'b1;
            owner_d   = CPU;
            cnt_d     = (owner_q == CPU) ? cnt_bump(cnt_q, BURST) : 4'd1;
          end
        end
        default: begin
          owner_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  assign cpu_gnt = grant_cpu;
  assign dma_gnt = grant_dma;
  assign issue   = grant_cpu | grant_dma;

  // Select the granted command; address/data registers only move when used.
  always_comb begin
    cmd = '0;
    if (grant_dma) begin
      cmd.we    = dma_we;
      cmd.addr  = SRAM_ADDR_W'(dma_addr);
      cmd.wdata = SRAM_DATA_W'(dma_wdata);
    end else if (grant_cpu) begin
      cmd.we    = cpu_we;
      cmd.addr  = SRAM_ADDR_W'(cpu_addr);
      cmd.wdata = SRAM_DATA_W'(cpu_wdata);
    end

    sram_wr_d      = issue &  cmd.we;
    sram_rd_d      = issue & ~cmd.we;
    sram_waddr_d   = sram_wr_d ? ADDR_W'(cmd.addr)  : sram_waddr_q;
    sram_wr_data_d = sram_wr_d ? DATA_W'(cmd.wdata) : sram_wr_data_q;
    sram_raddr_d   = sram_rd_d ? ADDR_W'(cmd.addr)  : sram_raddr_q;
  end

  // Return data passes straight through in its valid cycle and is held
  // afterwards, so the non-owner's rdata keeps its last value.
  always_comb begin
    cpu_rdata_d = cpu_rvalid ? sram_rd_data : cpu_rdata_q;
    dma_rdata_d = dma_rvalid ? sram_rd_data : dma_rdata_q;
  end

  assign cpu_rdata = cpu_rdata_d;
  assign dma_rdata = dma_rdata_d;

  // p0: grant registered onto the SRAM command port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q        <= IDLE;
      cnt_q          <= 4'd0;
      sram_rd_q      <= 1'b0;
      sram_wr_q      <= 1'b0;
      sram_raddr_q   <= '0;
      sram_waddr_q   <= '0;
      sram_wr_data_q <= '0;
      cpu_rdata_q    <= '0;
      dma_rdata_q    <= '0;
    end else begin
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      sram_rd_q      <= sram_rd_d;
      sram_wr_q      <= sram_wr_d;
      sram_raddr_q   <= sram_raddr_d;
      sram_waddr_q   <= sram_waddr_d;
      sram_wr_data_q <= sram_wr_data_d;
      cpu_rdata_q    <= cpu_rdata_d;
      dma_rdata_q    <= dma_rdata_d;
    end
  end

  assign sram_rd      = sram_rd_q;
  assign sram_wr      = sram_wr_q;
  assign sram_raddr   = sram_raddr_q;
  assign sram_waddr   = sram_waddr_q;
  assign sram_wr_data = sram_wr_data_q;

  sram_rd_tag_pipe u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_rd   (sram_rd_d),
    .issue_dma  (grant_dma),
    .cpu_rvalid (cpu_rvalid),
    .dma_rvalid (dma_rvalid)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int CPU_BURST = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [ADDR_W-1:0] sram_raddr, sram_waddr;
  logic              sram_rd, sram_wr;
  logic [DATA_W-1:0] sram_wr_data, sram_rd_data;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPU_BURST(CPU_BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .sram_raddr(sram_raddr), .sram_rd(sram_rd), .sram_waddr(sram_waddr),
    .sram_wr(sram_wr), .sram_wr_data(sram_wr_data), .sram_rd_data(sram_rd_data)
  );

  // SRAM: one-cycle read latency
  logic [DATA_W-1:0] mem [256];
  always @(posedge clk) begin
    if (sram_wr) mem[sram_waddr] <= sram_wr_data;
    if (sram_rd) sram_rd_data <= mem[sram_raddr];
  end

  typedef struct { bit we; logic [7:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { int due; bit dma; logic [31:0] data; } ret_t;
  typedef struct {
    logic cpu_gnt, dma_gnt, sram_wr, sram_rd, cpu_rvalid, dma_rvalid;
    logic [7:0] waddr, raddr;
    logic [31:0] wdata, cpu_rdata, dma_rdata;
  } snap_t;

  req_t  cq[$], dq[$];
  ret_t  rq[$];
  snap_t log_q[$];
  logic [31:0] ref_mem [256];

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int m_last = 0, m_run = 0;          // last grantee (0 none, 1 CPU, 2 DMA) and its streak
  logic e_wr = 1'b0, e_rd = 1'b0;
  logic [7:0]  e_waddr = '0, e_raddr = '0;
  logic [31:0] e_wdata = '0, last_cpu = '0, last_dma = '0;
  int cpu_rate = 100, dma_rate = 100, cpu_wait = 0, dma_wait = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (!rst_n) return 0;
    if (cpu_req && dma_req) return (m_last == 1 && m_run >= CPU_BURST) ? 2 : 1;
    if (cpu_req) return 1;
    if (dma_req) return 2;
    return 0;
  endfunction

  function automatic req_t rnd_cmd();
    req_t c;
    c.we    = ($urandom_range(1) == 1);
    c.addr  = 8'($urandom_range(15));
    c.wdata = $urandom();
    return c;
  endfunction

  task automatic drive();
    if (!cpu_req && cq.size() > 0 && int'($urandom_range(99)) < cpu_rate) begin
      cpu_req = 1'b1; cpu_we = cq[0].we; cpu_addr = cq[0].addr; cpu_wdata = cq[0].wdata;
    end
    if (!dma_req && dq.size() > 0 && int'($urandom_range(99)) < dma_rate) begin
      dma_req = 1'b1; dma_we = dq[0].we; dma_addr = dq[0].addr; dma_wdata = dq[0].wdata;
    end
  endtask

  task automatic cycle();
    int    g;
    ret_t  r;
    req_t  c;
    snap_t s;
    logic  x_crv, x_drv;
    drive();
    @(negedge clk);
    g = model_grant();
    chk1("cpu_gnt", cpu_gnt, g == 1);
    chk1("dma_gnt", dma_gnt, g == 2);
    chk1("gnt_two_hot", cpu_gnt & dma_gnt, 1'b0);
    chk1("sram_wr", sram_wr, e_wr);
    chk1("sram_rd", sram_rd, e_rd);
    chk32("sram_waddr", 32'(sram_waddr), 32'(e_waddr));
    chk32("sram_raddr", 32'(sram_raddr), 32'(e_raddr));
    chk32("sram_wr_data", sram_wr_data, e_wdata);
    x_crv = 1'b0; x_drv = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (rst_n) begin
        if (r.dma) begin x_drv = 1'b1; last_dma = r.data; end
        else       begin x_crv = 1'b1; last_cpu = r.data; end
      end
    end
    chk1("cpu_rvalid", cpu_rvalid, x_crv);
    chk1("dma_rvalid", dma_rvalid, x_drv);
    chk32("cpu_rdata", cpu_rdata, last_cpu);
    chk32("dma_rdata", dma_rdata, last_dma);
    cpu_wait = (rst_n && cpu_req && !cpu_gnt) ? cpu_wait + 1 : 0;
    dma_wait = (rst_n && dma_req && !dma_gnt) ? dma_wait + 1 : 0;
    chk1("cpu_wait_bound", cpu_wait <= 1, 1'b1);
    chk1("dma_wait_bound", dma_wait <= CPU_BURST, 1'b1);
    s.cpu_gnt = cpu_gnt; s.dma_gnt = dma_gnt; s.sram_wr = sram_wr; s.sram_rd = sram_rd;
    s.cpu_rvalid = cpu_rvalid; s.dma_rvalid = dma_rvalid; s.waddr = sram_waddr;
    s.raddr = sram_raddr; s.wdata = sram_wr_data; s.cpu_rdata = cpu_rdata; s.dma_rdata = dma_rdata;
    log_q.push_back(s);
    @(posedge clk); #1;
    if (!rst_n) begin
      m_last = 0; m_run = 0;
      e_wr = 1'b0; e_rd = 1'b0; e_waddr = '0; e_raddr = '0; e_wdata = '0;
      last_cpu = '0; last_dma = '0;
      rq.delete();
    end else if (g == 0) begin
      m_last = 0; m_run = 0;
      e_wr = 1'b0; e_rd = 1'b0;
    end else begin
      if (g == 1) begin c = cq.pop_front(); cpu_req = 1'b0; end
      else        begin c = dq.pop_front(); dma_req = 1'b0; end
      if (g == m_last) m_run = (m_run >= CPU_BURST) ? CPU_BURST : m_run + 1;
      else begin m_last = g; m_run = 1; end
      e_wr = c.we; e_rd = !c.we;
      if (c.we) begin
        e_waddr = c.addr; e_wdata = c.wdata; ref_mem[c.addr] = c.wdata;
      end else begin
        e_raddr = c.addr;
        rq.push_back('{due: cyc + 2, dma: (g == 2), data: ref_mem[c.addr]});
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 + 32'(i * 17);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    @(posedge clk); #1;

    // Reset: requests present but no grant, all outputs zero
    cq.push_back('{we: 1'b1, addr: 8'd15, wdata: 32'hA5});
    cq.push_back('{we: 1'b0, addr: 8'd15, wdata: 32'h0});
    b = cyc;
    cycle(); cycle();
    chk1("reset_cpu_gnt", log_q[b+1].cpu_gnt, 1'b0);
    chk1("reset_sram_wr", log_q[b+1].sram_wr, 1'b0);

    // CPU write 15 = A5 then read 15
    rst_n = 1'b1;
    b = cyc;
    repeat (5) cycle();
    chk1("t1_gnt0", log_q[b].cpu_gnt, 1'b1);
    chk1("t1_gnt1", log_q[b+1].cpu_gnt, 1'b1);
    chk1("t1_sram_wr", log_q[b+1].sram_wr, 1'b1);
    chk32("t1_waddr", 32'(log_q[b+1].waddr), 32'd15);
    chk32("t1_wdata", log_q[b+1].wdata, 32'hA5);
    chk1("t1_sram_rd", log_q[b+2].sram_rd, 1'b1);
    chk32("t1_raddr", 32'(log_q[b+2].raddr), 32'd15);
    chk1("t1_rvalid", log_q[b+3].cpu_rvalid, 1'b1);
    chk32("t1_rdata", log_q[b+3].cpu_rdata, 32'hA5);

    // DMA preload of addresses 0..15
    for (int i = 0; i < 16; i++) dq.push_back('{we: 1'b1, addr: 8'(i), wdata: pre(i)});
    repeat (18) cycle();

    // DMA-only burst of 8 reads
    for (int i = 0; i < 8; i++) dq.push_back('{we: 1'b0, addr: 8'(i), wdata: 32'h0});
    b = cyc;
    repeat (11) cycle();
    for (int k = 0; k < 8; k++) begin
      chk1("t4_dma_gnt", log_q[b+k].dma_gnt, 1'b1);
      chk1("t4_dma_rvalid", log_q[b+k+2].dma_rvalid, 1'b1);
      chk32("t4_dma_rdata", log_q[b+k+2].dma_rdata, pre(k));
    end
    chk1("t4_gnt_end", log_q[b+8].dma_gnt, 1'b0);
    chk1("t4_rvalid_end", log_q[b+10].dma_rvalid, 1'b0);

    // Both continuously reading: CPU, CPU, DMA, ...
    for (int i = 0; i < 6; i++) cq.push_back('{we: 1'b0, addr: 8'(i), wdata: 32'h0});
    for (int i = 0; i < 3; i++) dq.push_back('{we: 1'b0, addr: 8'(8 + i), wdata: 32'h0});
    b = cyc;
    repeat (12) cycle();
    for (int k = 0; k < 9; k++) begin
      chk1("t2_dma_gnt", log_q[b+k].dma_gnt, (k % 3) == 2);
      chk1("t2_cpu_gnt", log_q[b+k].cpu_gnt, (k % 3) != 2);
      chk1("t2_dma_rvalid", log_q[b+k+2].dma_rvalid, (k % 3) == 2);
      chk1("t2_cpu_rvalid", log_q[b+k+2].cpu_rvalid, (k % 3) != 2);
    end

    // DMA write 10 = 10, CPU reads 10 on the next cycle
    dq.push_back('{we: 1'b1, addr: 8'd10, wdata: 32'd10});
    b = cyc;
    cycle();
    cq.push_back('{we: 1'b0, addr: 8'd10, wdata: 32'h0});
    repeat (4) cycle();
    chk1("t3_dma_gnt", log_q[b].dma_gnt, 1'b1);
    chk1("t3_cpu_gnt", log_q[b+1].cpu_gnt, 1'b1);
    chk1("t3_rvalid", log_q[b+3].cpu_rvalid, 1'b1);
    chk32("t3_rdata", log_q[b+3].cpu_rdata, 32'd10);

    // Reset with two reads in flight
    dq.push_back('{we: 1'b0, addr: 8'd1, wdata: 32'h0});
    dq.push_back('{we: 1'b0, addr: 8'd2, wdata: 32'h0});
    b = cyc;
    cycle(); cycle();
    cq.push_back('{we: 1'b1, addr: 8'd3, wdata: 32'h1234_5678});
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    chk1("t5_gnt_in_reset", log_q[b+2].cpu_gnt, 1'b0);
    chk1("t5_rvalid_r0", log_q[b+2].dma_rvalid, 1'b0);
    chk1("t5_rvalid_r1", log_q[b+3].dma_rvalid, 1'b0);
    chk1("t5_rvalid_r2", log_q[b+4].dma_rvalid, 1'b0);
    chk1("t5_sram_rd", log_q[b+3].sram_rd, 1'b0);
    chk1("t5_sram_wr", log_q[b+3].sram_wr, 1'b0);
    chk32("t5_raddr", 32'(log_q[b+3].raddr), 32'd0);
    chk32("t5_dma_rdata", log_q[b+3].dma_rdata, 32'd0);
    chk1("t5_cpu_gnt_after", log_q[b+3].cpu_gnt, 1'b1);

    // CPU request withdrawn while DMA holds priority
    repeat (2) cycle();
    for (int i = 0; i < 3; i++) cq.push_back('{we: 1'b0, addr: 8'(4 + i), wdata: 32'h0});
    dq.push_back('{we: 1'b0, addr: 8'd7, wdata: 32'h0});
    b = cyc;
    repeat (3) cycle();
    cq.delete();
    cpu_req = 1'b0;
    repeat (4) cycle();
    chk1("t6_dma_gnt", log_q[b+2].dma_gnt, 1'b1);
    chk1("t6_cpu_gnt", log_q[b+3].cpu_gnt, 1'b0);
    chk32("t6_raddr", 32'(log_q[b+3].raddr), 32'd7);
    chk1("t6_idle_rd", log_q[b+4].sram_rd, 1'b0);
    chk1("t6_idle_wr", log_q[b+4].sram_wr, 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) begin
        cpu_rate = int'($urandom_range(20, 100));
        dma_rate = int'($urandom_range(20, 100));
      end
      if (cq.size() < 2) cq.push_back(rnd_cmd());
      if (dq.size() < 2) dq.push_back(rnd_cmd());
      cycle();
    end
    cpu_rate = 100; dma_rate = 100;
    for (int n = 0; n < 60 && (cq.size() > 0 || dq.size() > 0); n++) cycle();
    repeat (4) cycle();
    chk32("drain_cpu_queue", 32'(cq.size()), 32'd0);
    chk32("drain_dma_queue", 32'(dq.size()), 32'd0);
    chk32("drain_returns", 32'(rq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM port between two requesters: the CPU load/store path and a DMA/loader port that preloads and dumps memory.
- Issues at most one SRAM access per cycle, using weighted round-robin in the CPU's favour.
- Routes read data back to whichever requester issued the read.
- Sits between the CPU core and the SRAM model, and drives the sram_* signals that the CPU testbench monitor checks.

Parameters:
- ADDR_W, 8, SRAM word-address width.
- DATA_W, 32, SRAM data width.
- CPU_BURST, 2, maximum consecutive CPU grants while DMA is waiting (legal range 1..15).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* group, for the DMA requester.
- sram_raddr  out  ADDR_W  SRAM read address.
- sram_rd  out  1  SRAM read strobe.
- sram_waddr  out  ADDR_W  SRAM write address.
- sram_wr  out  1  SRAM write strobe.
- sram_wr_data  out  DATA_W  SRAM write data.
- sram_rd_data  in  DATA_W  SRAM read data, valid 1 cycle after a sram_rd cycle.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - All outputs go to 0, owner = IDLE, burst counter = 0, read-tag pipeline cleared.
  - Reads in flight when reset is applied are dropped: no rvalid is produced for them.
  - gnt outputs are forced 0 while rst_n = 0.
- Handshake:
  - A requester holds req/we/addr/wdata stable until it samples gnt = 1.
  - gnt is combinational from req and the registered arbiter state; it is never asserted without req.
  - At most one gnt per cycle (must be one-hot or zero).
- Command stage: a grant in cycle N registers the command onto the sram_* outputs, visible in cycle N+1.
  - Write: sram_waddr = addr, sram_wr_data = wdata, sram_wr = 1, sram_rd = 0.
  - Read: sram_raddr = addr, sram_rd = 1, sram_wr = 0.
  - No grant: sram_wr = sram_rd = 0; address and data registers hold their previous values.
- Read return:
  - Each read carries a 1-bit owner tag through a 2-stage pipeline.
  - The owner's rvalid pulses in cycle N+2 with rdata = sram_rd_data.
  - The rdata of the other requester holds its last value.
  - Back-to-back reads sustain 1 per cycle.
- Arbiter FSM; owner ∈ {IDLE, CPU, DMA}, plus burst counter cnt (4 bits):
  - Only one requester active: grant it. owner ← that requester. cnt ← cnt+1 if owner is unchanged, else cnt ← 1.
  - Both active, owner = DMA or IDLE: grant CPU, cnt ← 1.
  - Both active, owner = CPU, cnt < CPU_BURST: grant CPU, cnt+1.
  - Both active, owner = CPU, cnt = CPU_BURST: grant DMA, owner ← DMA, cnt ← 1.
  - Both active, owner = DMA: grant CPU (DMA never gets two consecutive grants while CPU waits).
  - No requests: owner ← IDLE, cnt ← 0.
  - cnt saturates at CPU_BURST and never wraps.
- Ordering: accesses reach the SRAM strictly in grant order. A write granted in cycle N followed by a read of the same address granted in N+1 returns the new data.
- Starvation bounds, with both requesters continuously active:
  - DMA waits at most CPU_BURST cycles.
  - CPU waits at most 1 cycle.
- Request withdrawn before grant: permitted; no access is issued for it.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef owner_e {IDLE, CPU, DMA};
  - typedef sram_cmd_t struct {we, addr, wdata};
  - localparam RD_LAT = 1.
- Sub-module sram_rd_tag_pipe: a 2-stage valid + owner shift register that produces the per-requester rvalid outputs.

Test Plan:
- Reset, then CPU only: write addr 15 = 0xA5, then read addr 15 → cpu_gnt in cycles 0 and 1; sram_wr = 1 with sram_waddr = 15, sram_wr_data = 0xA5 in cycle 1; sram_rd = 1 with sram_raddr = 15 in cycle 2; cpu_rvalid = 1 with cpu_rdata = 0xA5 in cycle 3.
- Both requesters continuously request reads, CPU_BURST = 2 → grant sequence CPU, CPU, DMA, CPU, CPU, DMA…; gnt is never two-hot; each rvalid is routed to the correct owner.
- DMA writes addr 10 = 10 in cycle N while the CPU reads addr 10 in cycle N+1 → cpu_rdata = 10 in cycle N+3.
- DMA-only burst of 8 reads of addr 0..7 → dma_gnt held high for 8 cycles; dma_rvalid high for 8 cycles starting 2 cycles later, with data in order.
- rst_n dropped while 2 reads are in flight → no rvalid afterwards; all sram_* outputs are 0 on the following cycle; owner = IDLE.
- CPU asserts req then withdraws it before grant (DMA holds priority) → no SRAM access for the CPU; sram_wr = sram_rd = 0 in idle cycles.
